// File: rtl/lcd_text_sequencer.sv
// Redraws a character LCD: clear, then per line a DDRAM address command followed by that line's characters.
// Optional macro LCD_SEQ_AUTO_REFRESH_EN: a change of exercise_id seen in IDLE also starts a redraw.
module lcd_text_sequencer #(
   parameter int CHARS_PER_LINE = 16,
   parameter int NUM_LINES      = 2,
   parameter int PACE_CYCLES    = 8_000_000,
   parameter int ID_W           = 4,
   localparam int ADDR_W = (CHARS_PER_LINE * NUM_LINES > 1) ? $clog2(CHARS_PER_LINE * NUM_LINES) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ID_W-1:0]   exercise_id,
   input  logic              start,
   output logic [ID_W-1:0]   rom_id,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [7:0]        rom_char,
   output logic [7:0]        drv_data,
   output logic              drv_rs,
   output logic              drv_valid,
   input  logic              drv_ready,
   output logic              busy,
   output logic              done
);

   localparam int COL_W  = (CHARS_PER_LINE > 1) ? $clog2(CHARS_PER_LINE) : 1;
   localparam int LINE_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
   localparam int PACE_W = (PACE_CYCLES > 0) ? $clog2(PACE_CYCLES + 1) : 1;

   localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(CHARS_PER_LINE - 1);
   localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(NUM_LINES - 1);
   localparam logic [PACE_W-1:0] PACE_LOAD = (PACE_CYCLES > 0) ? PACE_W'(PACE_CYCLES - 1) : '0;

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] CLEAR = 3'd1;
   localparam logic [2:0] LADDR = 3'd2;
   localparam logic [2:0] CHAR  = 3'd3;
   localparam logic [2:0] PACE  = 3'd4;
   localparam logic [2:0] FIN   = 3'd5;

   logic [2:0]        state;
   logic [2:0]        ret_state;
   logic [2:0]        beat_next;
   logic [COL_W-1:0]  col;
   logic [LINE_W-1:0] line;
   logic [PACE_W-1:0] pace_cnt;
   logic              launch;
   logic              accept;
   logic              last_beat;

   // HD44780-style DDRAM base of each line: lines 2/3 continue lines 0/1 after the visible width
   function automatic logic [7:0] line_base(input logic [LINE_W-1:0] l);
      logic [7:0] b;
      b = l[0] ? 8'h40 : 8'h00;
      if (32'(l) >= 32'd2) b = b + 8'(CHARS_PER_LINE);
      return b;
   endfunction

   function automatic logic [7:0] pad_char(input logic [7:0] c);
      return (c == 8'h00) ? 8'h20 : c;
   endfunction

`ifdef LCD_SEQ_AUTO_REFRESH_EN
   logic [ID_W-1:0] last_id;

   assign launch = (state == IDLE) && (start || (exercise_id != last_id));

   always_ff @(posedge clk) begin
      if (rst)         last_id <= '0;
      else if (launch) last_id <= exercise_id;
   end
`else
   assign launch = (state == IDLE) && start;
`endif

   assign drv_valid = (state == CLEAR) || (state == LADDR) || (state == CHAR);
   assign accept    = drv_valid && drv_ready;
   assign busy      = (state != IDLE);
   assign done      = (state == FIN);

   always_comb begin
      drv_data = 8'h00;
      drv_rs   = 1'b0;
      case (state)
         CLEAR: drv_data = 8'h01;
         LADDR: drv_data = 8'h80 | line_base(line);
         CHAR: begin
            drv_data = pad_char(rom_char);
            drv_rs   = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      beat_next = CHAR;
      last_beat = 1'b0;
      case (state)
         CLEAR: beat_next = LADDR;
         LADDR: beat_next = CHAR;
         CHAR: begin
            if (col == COL_LAST) begin
               if (line == LINE_LAST) last_beat = 1'b1;
               else                   beat_next = LADDR;
            end
         end
         default: ;
      endcase
   end

   // rom_addr advances with every character so the ROM output is already settled when CHAR is offered
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ret_state <= IDLE;
         col       <= '0;
         line      <= '0;
         pace_cnt  <= '0;
         rom_addr  <= '0;
         rom_id    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (launch) begin
                  rom_id   <= exercise_id;
                  col      <= '0;
                  line     <= '0;
                  rom_addr <= '0;
                  state    <= CLEAR;
               end
            end
            CLEAR, LADDR, CHAR: begin
               if (accept) begin
                  if (state == CHAR) begin
                     if (col == COL_LAST) begin
                        col  <= '0;
                        line <= line + LINE_W'(1);
                     end else begin
                        col <= col + COL_W'(1);
                     end
                     if (!last_beat) rom_addr <= rom_addr + ADDR_W'(1);
                  end
                  if (last_beat) begin
                     state <= FIN;
                  end else if (PACE_CYCLES == 0) begin
                     state <= beat_next;
                  end else begin
                     state     <= PACE;
                     ret_state <= beat_next;
                     pace_cnt  <= PACE_LOAD;
                  end
               end
            end
            PACE: begin
               if (pace_cnt == '0) state <= ret_state;
               else                pace_cnt <= pace_cnt - PACE_W'(1);
            end
            FIN:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_text_sequencer.sv
// Directed bench: 2x16 display paced by 2 cycles, plus a 4x20 display with no pacing.
module tb_lcd_text_sequencer;

   logic       clk;
   logic       rst;
   logic [3:0] exercise_id;
   logic       start;
   logic [3:0] rom_id;
   logic [4:0] rom_addr;
   logic [7:0] rom_char;
   logic [7:0] drv_data;
   logic       drv_rs;
   logic       drv_valid;
   logic       drv_ready;
   logic       busy;
   logic       done;
   bit         zero7;

   logic       start4;
   logic [3:0] id4;
   logic [3:0] rom_id4;
   logic [6:0] rom_addr4;
   logic [7:0] rom_char4;
   logic [7:0] data4;
   logic       rs4;
   logic       valid4;
   logic       ready4;
   logic       busy4;
   logic       done4;

   int vectors;
   int miscompares;
   int nb;
   int ndone;
   logic [7:0] bdata [0:127];
   logic       brs   [0:127];
   int         bgap  [0:127];

   function automatic logic [7:0] rom_fn(input int addr, input int cpl, input bit z);
      int c;
      c = addr % cpl;
      return (z && c == 7) ? 8'h00 : 8'(8'h41 + c);
   endfunction

   assign rom_char  = rom_fn(int'(rom_addr), 16, zero7);
   assign rom_char4 = rom_fn(int'(rom_addr4), 20, 1'b0);

   lcd_text_sequencer #(.CHARS_PER_LINE(16), .NUM_LINES(2), .PACE_CYCLES(2), .ID_W(4)) u_dut (
      .clk(clk), .rst(rst), .exercise_id(exercise_id), .start(start),
      .rom_id(rom_id), .rom_addr(rom_addr), .rom_char(rom_char),
      .drv_data(drv_data), .drv_rs(drv_rs), .drv_valid(drv_valid), .drv_ready(drv_ready),
      .busy(busy), .done(done)
   );

   lcd_text_sequencer #(.CHARS_PER_LINE(20), .NUM_LINES(4), .PACE_CYCLES(0), .ID_W(4)) u_dut4 (
      .clk(clk), .rst(rst), .exercise_id(id4), .start(start4),
      .rom_id(rom_id4), .rom_addr(rom_addr4), .rom_char(rom_char4),
      .drv_data(data4), .drv_rs(rs4), .drv_valid(valid4), .drv_ready(ready4),
      .busy(busy4), .done(done4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // expected {rs, data} of beat idx for a display cpl characters wide
   function automatic logic [8:0] exp_beat(input int idx, input int cpl, input bit z7);
      int j, ln, p, c, base;
      if (idx == 0) return 9'h001;
      j  = idx - 1;
      ln = j / (cpl + 1);
      p  = j % (cpl + 1);
      if (p == 0) begin
         base = ((ln % 2) == 1 ? 'h40 : 0) + (ln >= 2 ? cpl : 0);
         return {1'b0, 8'(8'h80 | base)};
      end
      c = p - 1;
      return {1'b1, (z7 && c == 7) ? 8'h20 : 8'(8'h41 + c)};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic collect(input int stall_idx, input int stall_len, input int stop_at,
                          input int pulse_idx, input logic [3:0] id_exp, output bit stopped);
      int idle, left, cyc;
      bit fin;
      idle = 0; left = stall_len; cyc = 0; fin = 0;
      nb = 0; ndone = 0; stopped = 0;
      while (!fin && cyc < 500) begin
         start = 1'b0;
         if (drv_valid && nb == stop_at) begin
            stopped = 1;
            fin = 1;
         end else begin
            if (done) begin
               ndone++;
               chk("fin_busy", busy, 1);
               fin = 1;
            end else if (drv_valid) begin
               if (nb == stall_idx && left > 0) begin
                  drv_ready = 1'b0;
                  left--;
                  chk("stall_hold", {drv_valid, drv_rs, drv_data}, {1'b1, exp_beat(nb, 16, zero7)});
               end else begin
                  drv_ready = 1'b1;
                  bdata[nb] = drv_data;
                  brs[nb]   = drv_rs;
                  bgap[nb]  = idle;
                  idle = 0;
                  if (nb == pulse_idx) begin
                     start = 1'b1;
                     exercise_id = 4'h9;
                  end
                  if (pulse_idx >= 0 && nb == pulse_idx + 1) begin
                     chk("rom_id_hold", rom_id, id_exp);
                     exercise_id = id_exp;
                  end
                  nb++;
               end
            end else begin
               idle++;
            end
            step();
            cyc++;
         end
      end
      if (!stopped) begin
         chk("done_seen", ndone, 1);
         chk("done_clear", done, 0);
         chk("idle_after", busy, 0);
      end
   endtask

   task automatic check_beats(input string tag, input int pace);
      chk({tag, "_count"}, nb, 35);
      for (int i = 0; i < 35; i++) begin
         if (i < nb) begin
            chk($sformatf("%s_beat%0d", tag, i), {brs[i], bdata[i]}, exp_beat(i, 16, zero7));
            if (i > 0) chk($sformatf("%s_gap%0d", tag, i), bgap[i], pace);
         end
      end
   endtask

   initial begin
      bit st;
      int n4, idle4, cyc4;
      logic [8:0] b4 [0:127];
      vectors = 0; miscompares = 0;
      rst = 1'b1; start = 1'b0; exercise_id = 4'h0; drv_ready = 1'b1; zero7 = 0;
      start4 = 1'b0; id4 = 4'h0; ready4 = 1'b1;
      step(); step();
      chk("rst_valid", drv_valid, 0);
      chk("rst_data", drv_data, 8'h00);
      chk("rst_rs", drv_rs, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_addr", rom_addr, 0);
      chk("rst_id", rom_id, 0);
      rst = 1'b0;
      step();
      chk("idle_busy", busy, 0);

      // plain redraw; a start and an id change mid-redraw must be ignored
      exercise_id = 4'h6; start = 1'b1;
      step();
      chk("first_busy", busy, 1);
      chk("first_valid", drv_valid, 1);
      chk("first_data", {drv_rs, drv_data}, 9'h001);
      chk("first_id", rom_id, 6);
      collect(-1, 0, -1, 5, 4'h6, st);
      check_beats("r1", 2);
      step(); step();
      chk("start_ignored", busy, 0);

      // backpressure on the third beat, ROM returning 0x00 at column 7
      zero7 = 1;
      start = 1'b1;
      step();
      collect(2, 5, -1, -1, 4'h6, st);
      check_beats("r2", 2);
      zero7 = 0;

      // reset on the 10th beat, asserted together with start and with drv_ready low
      start = 1'b1;
      step();
      collect(-1, 0, 9, -1, 4'h6, st);
      chk("stopped_at_10", st, 1);
      rst = 1'b1; start = 1'b1; drv_ready = 1'b0; exercise_id = 4'h0;
      step();
      start = 1'b0;
      chk("mid_rst_valid", drv_valid, 0);
      chk("mid_rst_data", drv_data, 8'h00);
      chk("mid_rst_rs", drv_rs, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_addr", rom_addr, 0);
      chk("mid_rst_id", rom_id, 0);
      rst = 1'b0;
      step();
      chk("post_rst_done", done, 0);
      chk("post_rst_busy", busy, 0);
      start = 1'b1;
      step();
      collect(-1, 0, -1, -1, 4'h0, st);
      check_beats("r3", 2);

`ifdef LCD_SEQ_AUTO_REFRESH_EN
      exercise_id = 4'h3; start = 1'b1;
      step();
      chk("auto_id3", rom_id, 3);
      collect(-1, 0, -1, -1, 4'h3, st);
      exercise_id = 4'h5;
      step();
      chk("auto_busy", busy, 1);
      chk("auto_id5", rom_id, 5);
      chk("auto_first", {drv_rs, drv_data}, 9'h001);
      collect(-1, 0, -1, -1, 4'h5, st);
      chk("auto_count", nb, 35);
`endif

      // 4x20 display, unpaced
      start4 = 1'b1;
      step();
      start4 = 1'b0;
      n4 = 0; idle4 = 0; cyc4 = 0;
      while (!done4 && cyc4 < 300) begin
         if (valid4) begin
            if (n4 < 128) b4[n4] = {rs4, data4};
            n4++;
         end else begin
            idle4++;
         end
         step();
         cyc4++;
      end
      chk("l4_done", done4, 1);
      chk("l4_count", n4, 85);
      chk("l4_nogap", idle4, 0);
      for (int i = 0; i < 85; i++)
         if (i < n4) chk($sformatf("l4_beat%0d", i), b4[i], exp_beat(i, 20, 1'b0));
      step();
      chk("l4_idle", busy4, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
